// File: rtl/bus_cycle_ctrl.sv
// Machine-cycle sequencer: walks T-states, drives bus strobes, honours wait/timeout, emits refresh address.
// Request-to-T1 latency 1 clk; backpressure via cyc_ready, high only in idle or the final T-state.
module bus_cycle_ctrl #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 8,
   parameter int IO_AUTO_WAIT = 1,
   parameter int MAX_WAIT     = 255,
   parameter int RFSH_W       = 7
) (
   input  logic              clk,
   input  logic              rst_L,
   input  logic              cyc_start,
   input  logic [2:0]        cyc_type,
   input  logic [ADDR_W-1:0] cyc_addr,
   input  logic [DATA_W-1:0] cyc_wdata,
   output logic              cyc_ready,
   output logic              cyc_done,
   output logic              cyc_err,
   output logic [DATA_W-1:0] cyc_rdata,
   output logic [2:0]        t_state,
   output logic [ADDR_W-1:0] addr_out,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   output logic              mreq_L,
   output logic              iorq_L,
   output logic              rd_L,
   output logic              wr_L,
   output logic              m1_L,
   output logic              rfsh_L,
   input  logic              wait_L
);

   localparam int                WCNT_W     = $clog2(MAX_WAIT + 1);
   localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(MAX_WAIT);
   localparam logic [1:0]        AUTO_WAITS = 2'(IO_AUTO_WAIT);

   localparam logic [2:0] TY_OCF    = 3'd0;
   localparam logic [2:0] TY_MEM_RD = 3'd1;
   localparam logic [2:0] TY_MEM_WR = 3'd2;
   localparam logic [2:0] TY_IO_RD  = 3'd3;
   localparam logic [2:0] TY_IO_WR  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_TW   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5
   } tstate_t;

   typedef struct packed {
      logic [2:0]        kind;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   tstate_t           state_q, state_nxt;
   req_t              req_q;
   logic [WCNT_W-1:0] wait_cnt_q;
   logic [1:0]        auto_q;
   logic [RFSH_W-1:0] rfsh_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] addr_hold_q;
   logic              err_q;

   logic is_ocf, is_io, is_rd, final_st, accept, legal_in, in_io_in;
   logic wait_inc, abort, capture, body, late;

   assign is_ocf   = (req_q.kind == TY_OCF);
   assign is_io    = (req_q.kind == TY_IO_RD) || (req_q.kind == TY_IO_WR);
   assign is_rd    = is_ocf || (req_q.kind == TY_MEM_RD) || (req_q.kind == TY_IO_RD);
   assign final_st = (state_q == S_T4) || ((state_q == S_T3) && !is_ocf);
   assign accept   = cyc_start && cyc_ready;
   assign legal_in = (cyc_type <= TY_IO_WR);
   assign in_io_in = (cyc_type == TY_IO_RD) || (cyc_type == TY_IO_WR);

   assign cyc_ready = (state_q == S_IDLE) || final_st;
   assign cyc_done  = final_st;
   assign cyc_err   = err_q;
   assign cyc_rdata = rdata_q;
   assign t_state   = state_q;

   // Wait_L is only looked at once the automatic IO waits have drained.
   always_comb begin
      state_nxt = state_q;
      wait_inc  = 1'b0;
      abort     = 1'b0;
      capture   = 1'b0;
      case (state_q)
         S_IDLE: if (accept) state_nxt = legal_in ? S_T1 : S_IDLE;
         S_T1:   state_nxt = S_T2;
         S_T2, S_TW: begin
            if (auto_q != '0) begin
               state_nxt = S_TW;
            end else if (wait_L) begin
               state_nxt = S_T3;
               capture   = is_rd;
            end else if (wait_cnt_q == WAIT_LIMIT) begin
               state_nxt = S_IDLE;
               abort     = 1'b1;
            end else begin
               state_nxt = S_TW;
               wait_inc  = 1'b1;
            end
         end
         S_T3: begin
            if (is_ocf)      state_nxt = S_T4;
            else if (accept) state_nxt = legal_in ? S_T1 : S_IDLE;
            else             state_nxt = S_IDLE;
         end
         S_T4: begin
            if (accept) state_nxt = legal_in ? S_T1 : S_IDLE;
            else        state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_L) state_q <= S_IDLE;
      else        state_q <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_L) begin
         req_q       <= '0;
         wait_cnt_q  <= '0;
         auto_q      <= '0;
         rfsh_q      <= '0;
         rdata_q     <= '0;
         addr_hold_q <= '0;
         err_q       <= 1'b0;
      end else begin
         err_q       <= abort || (accept && !legal_in);
         addr_hold_q <= addr_out;
         if (accept) begin
            req_q      <= {cyc_type, cyc_addr, cyc_wdata};
            wait_cnt_q <= '0;
            auto_q     <= in_io_in ? AUTO_WAITS : 2'd0;
         end else begin
            if (wait_inc) wait_cnt_q <= wait_cnt_q + 1'b1;
            if ((auto_q != '0) && ((state_q == S_T2) || (state_q == S_TW)))
               auto_q <= auto_q - 1'b1;
         end
         if (capture) rdata_q <= data_in;
         if (state_q == S_T4) rfsh_q <= rfsh_q + 1'b1;
      end
   end

   assign body = (state_q == S_T1) || (state_q == S_T2) || (state_q == S_TW) || (state_q == S_T3);
   assign late = (state_q == S_T2) || (state_q == S_TW) || (state_q == S_T3);

   always_comb begin
      m1_L     = 1'b1;
      mreq_L   = 1'b1;
      iorq_L   = 1'b1;
      rd_L     = 1'b1;
      wr_L     = 1'b1;
      rfsh_L   = 1'b1;
      data_oe  = 1'b0;
      addr_out = addr_hold_q;
      if (state_q == S_T4) begin
         mreq_L   = 1'b0;
         rfsh_L   = 1'b0;
         addr_out = ADDR_W'(rfsh_q);
      end else if (body) begin
         addr_out = req_q.addr;
         case (req_q.kind)
            TY_OCF: begin
               m1_L   = 1'b0;
               mreq_L = 1'b0;
               rd_L   = 1'b0;
            end
            TY_MEM_RD: begin
               mreq_L = 1'b0;
               rd_L   = 1'b0;
            end
            TY_MEM_WR: begin
               mreq_L  = 1'b0;
               data_oe = 1'b1;
               wr_L    = !late;
            end
            TY_IO_RD: begin
               iorq_L = !late;
               rd_L   = !late;
            end
            TY_IO_WR: begin
               iorq_L  = !late;
               wr_L    = !late;
               data_oe = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign data_out = data_oe ? req_q.wdata : '0;

endmodule

// File: doc/bus_cycle_ctrl.md
BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
  ADDR_W, 16, address width
  DATA_W, 8, data width
  IO_AUTO_WAIT, 1, automatic wait states on IO cycles (0..3)
  MAX_WAIT, 255, external wait states allowed before timeout (>=1)
  RFSH_W, 7, refresh counter width
REQ-002 SHALL have ports, one per line:
  clk  in  1  single clock; all state on posedge
  rst_L  in  1  reset, synchronous, active-low
  cyc_start  in  1  machine-cycle request
  cyc_type  in  3  0 OCF, 1 MEM_RD, 2 MEM_WR, 3 IO_RD, 4 IO_WR, 5-7 illegal
  cyc_addr  in  ADDR_W  cycle address
  cyc_wdata  in  DATA_W  write data
  cyc_ready  out  1  request accepted this cycle if cyc_start high
  cyc_done  out  1  one-cycle completion pulse
  cyc_err  out  1  one-cycle pulse: illegal type or wait timeout
  cyc_rdata  out  DATA_W  read/fetch data, held until next capture
  t_state  out  3  0 idle, 1 T1, 2 T2, 3 TW, 4 T3, 5 T4
  addr_out  out  ADDR_W  external address
  data_in  in  DATA_W  external data in
  data_out  out  DATA_W  external data out
  data_oe  out  1  data_out valid/driven
  mreq_L, iorq_L, rd_L, wr_L, m1_L, rfsh_L  out  1 each  active-low strobes
  wait_L  in  1  active-low wait request

Function
REQ-003 SHALL accept a request on any posedge where cyc_start=1 and cyc_ready=1; cyc_type, cyc_addr and cyc_wdata are latched then, and T1 begins the next cycle.
REQ-004 cyc_ready SHALL be 1 in idle and in the final state of a cycle (T4 for OCF, T3 otherwise); acceptance in the final state goes straight to T1, no idle bubble.
REQ-005 State sequences: OCF T1,T2,[TW..],T3,T4; MEM_RD/MEM_WR T1,T2,[TW..],T3; IO T1,T2,TW x IO_AUTO_WAIT,[TW..],T3.
REQ-006 wait_L SHALL be sampled in T2 and in each TW after the automatic ones; 0 -> (next) TW, 1 -> T3.
REQ-007 Consecutive external TW states SHALL be counted; if wait_L is still 0 when the count equals MAX_WAIT, the cycle aborts: cyc_err pulses the next cycle, strobes deassert, state -> idle, no cyc_done.
REQ-008 cyc_rdata SHALL capture data_in on the edge leaving T2/last TW into T3 for OCF, MEM_RD, IO_RD; unchanged otherwise.
REQ-009 cyc_done SHALL be 1 exactly during the final state of a non-aborted cycle.
REQ-010 addr_out = latched address T1..T3; in OCF T4 addr_out = zero-extended refresh counter R; idle holds last value.
REQ-011 OCF: m1_L, mreq_L, rd_L = 0 in T1..T3 (incl. TW); T4 mreq_L=0, rfsh_L=0, others 1.
REQ-012 MEM_RD: mreq_L, rd_L = 0 T1..T3. MEM_WR: mreq_L = 0 T1..T3, wr_L = 0 T2..T3, data_oe = 1 T1..T3.
REQ-013 IO_RD/IO_WR: iorq_L and rd_L/wr_L = 0 from T2 through T3; IO_WR data_oe = 1 T1..T3.
REQ-014 data_out SHALL equal latched wdata whenever data_oe=1.
REQ-015 R SHALL increment modulo 2^RFSH_W at the end of each OCF T4; 2^RFSH_W-1 wraps to 0.
REQ-016 Illegal cyc_type SHALL be accepted, produce no strobes, pulse cyc_err the next cycle and return to idle.
REQ-017 Strobes not named active in a state SHALL be 1.

Reset
REQ-018 With rst_L=0 at posedge: t_state=0, all strobes 1, data_oe=0, cyc_done=0, cyc_err=0, cyc_ready=1, addr_out=0, data_out=0, cyc_rdata=0, R=0, wait counter 0.
REQ-019 Reset mid-cycle SHALL abort immediately with no cyc_done or cyc_err.

Verification
REQ-020 OCF addr 16'h1234, wait_L=1, data_in=8'hED at T2 -> t_state 1,2,4,5; cyc_rdata=8'hED; T4 addr_out=R=0; R=1 afterwards.
REQ-021 MEM_WR addr 16'hBBAA wdata 8'hEE, wait_L=0 for 2 cycles -> T1,T2,TW,TW,T3; wr_L low 4 cycles; data_out=8'hEE.
REQ-022 IO_RD IO_AUTO_WAIT=1, wait_L=1 -> T1,T2,TW,T3; iorq_L low 3 cycles; cyc_done in T3.
REQ-023 MEM_RD with MAX_WAIT=3, wait_L held 0 -> 3 TW then cyc_err pulse, idle, no cyc_done.
REQ-024 Back-to-back MEM_RD requested in T3 -> next cycle T1; 128 OCFs with RFSH_W=7 -> R wraps to 0; rst_L=0 in TW -> idle outputs next cycle.
